wb_dbg_master: RTL
==================

# wb_dbg_master

Wishbone bus initiator driven by a byte stream, for host-side debug access to the SoC peripheral bus. It accepts framed read and write commands from an upstream byte source, such as the existing UART byte core, and runs single Wishbone cycles against the same responders the CPU uses. It then returns a status frame on an outbound byte stream. It sits as a second initiator beside the CPU, in front of the bus arbiter.

## Interface
Parameters:
- `AW`, default 16: Wishbone word-address width, 1..16. The two address bytes are truncated to `AW`.
- `TIMEOUT_W`, default 8: width of the bus-timeout counter.

Ports:
- `clk`, input, 1: system clock. The block uses only this clock.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `rx_data`, input, 8: inbound command byte.
- `rx_valid`, input, 1: inbound byte valid.
- `rx_ready`, output, 1: block accepts the inbound byte.
- `tx_data`, output, 8: outbound response byte.
- `tx_valid`, output, 1: outbound byte valid.
- `tx_ready`, input, 1: downstream accepts the outbound byte.
- `wb_addr`, output, AW: word address.
- `wb_wdata`, output, 32: write data.
- `wb_wmsk`, output, 4: byte write mask.
- `wb_we`, output, 1: write enable.
- `wb_cyc`, output, 1: cycle request.
- `wb_rdata`, input, 32: read data.
- `wb_ack`, input, 1: cycle acknowledge.
- `busy`, output, 1: a command is in progress (any state other than IDLE).

## Operation
Command byte layout: bits [7:4] are the opcode and bits [3:0] are the mask.
- Opcode `0x1` is READ. The mask is ignored and `wb_wmsk` is driven to 0.
- Opcode `0x2` is WRITE. The mask nibble drives `wb_wmsk` exactly as received; mask 0 is legal and is issued as-is.

Frames:
- READ: cmd, addr_hi, addr_lo.
- WRITE: cmd, addr_hi, addr_lo, then d3, d2, d1, d0, most-significant byte first.

Responses:
- READ: status byte, then 4 data bytes MSB first. The 4 data bytes are sent even on error, with data 0x00000000.
- WRITE: status byte only.
- Status codes: OK 0x00, TIMEOUT 0x01, BADCMD 0x02.

An unknown opcode gets the BADCMD byte as its only response, after which the block returns to IDLE. Only the command byte is consumed.

State machine:
- IDLE: on accepting a READ or WRITE command, go to ADDR_H; on any other opcode, go to RESP.
- ADDR_H → ADDR_L.
- ADDR_L: go to DATA for a write, to BUS for a read.
- DATA: stays for 4 byte accepts, then → BUS.
- BUS: go to RESP when `wb_ack` is sampled high, or on timeout.
- RESP: sends 1 or 5 bytes, then → IDLE.

Datapath rules:
- The address is {addr_hi, addr_lo}[AW-1:0].
- Write data is assembled by a left-shift register: data = {data[23:0], byte}.
- Read data is captured into a 32-bit register on the ack cycle and shifted out MSB first.
- `rx_ready` is asserted only in IDLE, ADDR_H, ADDR_L and DATA. A byte is consumed when `rx_valid & rx_ready`.

## Timing
- Every output is registered.
- Reset values: `rx_ready`=0, `tx_valid`=0, `tx_data`=0, `wb_cyc`=0, `wb_we`=0, `wb_addr`=0, `wb_wdata`=0, `wb_wmsk`=0, `busy`=0.
- `rx_ready` rises on the first clock after `rst_n` deasserts.
- `wb_cyc` rises the cycle after the last frame byte is accepted.
- `wb_addr`, `wb_we`, `wb_wdata` and `wb_wmsk` are valid from that same cycle and held stable while `wb_cyc` is high.
- `wb_cyc` falls the cycle after `wb_ack` is sampled high.
  - A zero-wait responder with `ack = cyc` therefore gives a 2-cycle bus phase.
  - Any `wb_ack` seen while `wb_cyc` is low is ignored.
- The first response byte is presented with `tx_valid` high the cycle after `wb_cyc` falls.
- Each response byte is held until `tx_valid & tx_ready`. The next byte follows in the next cycle, so back-to-back response bytes run at 1 byte per cycle.
- `busy` is high from the cycle after the command byte is accepted until the last response byte handshakes.
- `rst_n` asserted mid-frame or mid-bus-cycle drops `wb_cyc` and `tx_valid` immediately (asynchronous). No partial response is sent after reset.
- Inbound bytes arriving while the block is in BUS or RESP are back-pressured, not dropped.

## Configuration
The `WB_DBG_TIMEOUT_EN` macro controls the bus timeout.
- Defined:
  - A `TIMEOUT_W`-bit counter clears when `wb_cyc` rises and increments each cycle that `wb_ack` is low.
  - When the counter reaches all-ones with no ack, the block drops `wb_cyc` and reports status TIMEOUT. A READ returns zero data.
  - If `wb_ack` arrives in the same cycle the counter reaches all-ones, the ack wins and the status is OK.
- Undefined: there is no counter, BUS waits indefinitely for `wb_ack`, and status TIMEOUT is never produced.

## Structure
- Package `wb_dbg_pkg` holds:
  - the opcode constants READ/WRITE;
  - the status codes OK/TIMEOUT/BADCMD;
  - the state encoding IDLE, ADDR_H, ADDR_L, DATA, BUS, RESP.
- One sub-module, `wb_dbg_wdog`: the timeout counter, with inputs start, ack and en and output expired. It is instantiated only under `WB_DBG_TIMEOUT_EN`.
- Everything else lives in one FSM/datapath module.

## Test plan
- Read with a zero-wait responder: feed 0x10,0x00,0x04 while the responder returns 0xDEADBEEF. Expect `wb_addr`=0x0004, `wb_we`=0, `wb_cyc` high for exactly 2 cycles, and tx bytes 0x00,0xDE,0xAD,0xBE,0xEF.
- Masked write: feed 0x23,0x01,0x02,0x11,0x22,0x33,0x44. Expect one cycle with `wb_addr`=0x0102, `wb_wdata`=0x11223344, `wb_wmsk`=0x3 and `wb_we`=1, followed by tx byte 0x00.
- Bad opcode: feed 0x70. Expect tx byte 0x02, no `wb_cyc`, then a following 0x10,0x00,0x00 read completes normally.
- Timeout with `TIMEOUT_W`=4 and the macro defined: issue a READ to a silent responder. Expect `wb_cyc` to drop after 15 cycles and tx bytes 0x01,0x00,0x00,0x00,0x00. With the macro undefined, `wb_cyc` must still be high after 1000 cycles.
- Backpressure on both sides:
  - hold `tx_ready`=0 for 20 cycles during RESP: `tx_data` stays stable and `rx_ready` stays 0;
  - toggle `rx_valid` randomly during the frame: the result is unchanged.
- Reset mid-cycle: assert `rst_n`=0 while `wb_cyc`=1 with ack withheld. `wb_cyc` and `tx_valid` go to 0 without waiting for a clock edge, and after release the next READ returns OK.

Source files
------------

// File: rtl/wb_dbg_pkg.sv
// wb_dbg_pkg: shared constants for the byte-stream Wishbone debug initiator.
//   - command opcodes (upper nibble of the command byte)
//   - response status codes
//   - FSM state encoding
package wb_dbg_pkg;

  localparam logic [3:0] OP_READ  = 4'h1;
  localparam logic [3:0] OP_WRITE = 4'h2;

  localparam logic [7:0] STAT_OK      = 8'h00;
  localparam logic [7:0] STAT_TIMEOUT = 8'h01;
  localparam logic [7:0] STAT_BADCMD  = 8'h02;

  typedef enum logic [2:0] {
    IDLE,
    ADDR_H,
    ADDR_L,
    DATA,
    BUS,
    RESP
  } state_e;

endpackage

// File: rtl/wb_dbg_wdog.sv
// wb_dbg_wdog: bus-cycle watchdog for wb_dbg_master.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : pulse on the cycle before wb_cyc rises; clears the count
//   ack        : raw wb_ack from the responder
//   en         : bus cycle in progress
//   expired    : no ack for 2**W - 1 cycles; asserted combinationally in the
//                cycle whose ack-low edge brings the count to all-ones
// Only instantiated when WB_DBG_TIMEOUT_EN is defined.
module wb_dbg_wdog #(
  parameter int unsigned W = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic ack,
  input  logic en,
  output logic expired
);

  localparam logic [W-1:0] CNT_LAST = W'({W{1'b1}} - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = '0;
    end else if (en && !ack) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Fires on the edge that would make the count all-ones, so the cycle
  // ends after exactly 2**W - 1 ack-less cycles; an ack in that cycle wins.
  assign expired = en && !ack && (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/wb_dbg_master.sv
// wb_dbg_master: Wishbone initiator driven by framed command bytes.
//   Inbound  : rx_data/rx_valid/rx_ready  (cmd, addr_hi, addr_lo[, d3..d0])
//   Outbound : tx_data/tx_valid/tx_ready  (status[, 4 read-data bytes MSB first])
//   Bus      : wb_addr, wb_wdata, wb_wmsk, wb_we, wb_cyc, wb_rdata, wb_ack
//   busy     : any state other than IDLE
// All outputs are registered. Define WB_DBG_TIMEOUT_EN to enable the bus
// watchdog (TIMEOUT_W-bit counter); otherwise BUS waits forever for ack.
module wb_dbg_master
  import wb_dbg_pkg::*;
#(
  parameter int unsigned AW        = 16,
  parameter int unsigned TIMEOUT_W = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  output logic          rx_ready,
  output logic [7:0]    tx_data,
  output logic          tx_valid,
  input  logic          tx_ready,
  output logic [AW-1:0] wb_addr,
  output logic [31:0]   wb_wdata,
  output logic [3:0]    wb_wmsk,
  output logic          wb_we,
  output logic          wb_cyc,
  input  logic [31:0]   wb_rdata,
  input  logic          wb_ack,
  output logic          busy
);

  state_e        state_q, state_d;
  logic          rx_ready_q, rx_ready_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_valid_q, tx_valid_d;
  logic [AW-1:0] wb_addr_q, wb_addr_d;
  logic [31:0]   wb_wdata_q, wb_wdata_d;
  logic [3:0]    wb_wmsk_q, wb_wmsk_d;
  logic          wb_we_q, wb_we_d;
  logic          wb_cyc_q, wb_cyc_d;
  logic          busy_q, busy_d;
  logic [7:0]    addr_hi_q, addr_hi_d;
  logic [1:0]    byte_cnt_q, byte_cnt_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [2:0]    resp_left_q, resp_left_d;
  logic          ack_seen_q, ack_seen_d;
  logic          rx_acc;
  logic          expired;

`ifdef WB_DBG_TIMEOUT_EN
  logic bus_start;
  logic bus_active;

  assign bus_start  = (state_q != BUS) && (state_d == BUS);
  assign bus_active = (state_q == BUS);

  wb_dbg_wdog #(
    .W (TIMEOUT_W)
  ) u_wdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (bus_start),
    .ack     (wb_ack),
    .en      (bus_active),
    .expired (expired)
  );
`else
  assign expired = 1'b0;
`endif

  assign rx_acc = rx_valid && rx_ready_q;

  always_comb begin
    state_d     = state_q;
    tx_data_d   = tx_data_q;
    tx_valid_d  = tx_valid_q;
    wb_addr_d   = wb_addr_q;
    wb_wdata_d  = wb_wdata_q;
    wb_wmsk_d   = wb_wmsk_q;
    wb_we_d     = wb_we_q;
    wb_cyc_d    = wb_cyc_q;
    addr_hi_d   = addr_hi_q;
    byte_cnt_d  = byte_cnt_q;
    rdata_d     = rdata_q;
    resp_left_d = resp_left_q;
    ack_seen_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (rx_acc) begin
          if (rx_data[7:4] == OP_READ || rx_data[7:4] == OP_WRITE) begin
            state_d   = ADDR_H;
            wb_we_d   = (rx_data[7:4] == OP_WRITE);
            wb_wmsk_d = (rx_data[7:4] == OP_WRITE) ? rx_data[3:0] : 4'h0;
          end else begin
            state_d     = RESP;
            tx_valid_d  = 1'b1;
            tx_data_d   = STAT_BADCMD;
            resp_left_d = 3'd0;
          end
        end
      end
      ADDR_H: begin
        if (rx_acc) begin
          addr_hi_d = rx_data;
          state_d   = ADDR_L;
        end
      end
      ADDR_L: begin
        if (rx_acc) begin
          wb_addr_d = AW'({addr_hi_q, rx_data});
          if (wb_we_q) begin
            state_d    = DATA;
            byte_cnt_d = 2'd0;
          end else begin
            state_d  = BUS;
            wb_cyc_d = 1'b1;
          end
        end
      end
      DATA: begin
        if (rx_acc) begin
          wb_wdata_d = {wb_wdata_q[23:0], rx_data};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            state_d  = BUS;
            wb_cyc_d = 1'b1;
          end
        end
      end
      BUS: begin
        // Ack is registered first and acted on one edge later, so a
        // zero-wait responder holds wb_cyc for two cycles.
        if (ack_seen_q) begin
          state_d     = RESP;
          wb_cyc_d    = 1'b0;
          tx_valid_d  = 1'b1;
          tx_data_d   = STAT_OK;
          resp_left_d = wb_we_q ? 3'd0 : 3'd4;
        end else if (wb_ack && wb_cyc_q) begin
          ack_seen_d = 1'b1;
          rdata_d    = wb_rdata;
        end else if (expired) begin
          state_d     = RESP;
          wb_cyc_d    = 1'b0;
          tx_valid_d  = 1'b1;
          tx_data_d   = STAT_TIMEOUT;
          rdata_d     = '0;
          resp_left_d = wb_we_q ? 3'd0 : 3'd4;
        end
      end
      RESP: begin
        if (tx_valid_q && tx_ready) begin
          if (resp_left_q != 3'd0) begin
            tx_data_d   = rdata_q[31:24];
            rdata_d     = {rdata_q[23:0], 8'h00};
            resp_left_d = resp_left_q - 3'd1;
          end else begin
            tx_valid_d = 1'b0;
            state_d    = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    rx_ready_d = (state_d == IDLE) || (state_d == ADDR_H) ||
                 (state_d == ADDR_L) || (state_d == DATA);
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rx_ready_q  <= 1'b0;
      tx_data_q   <= '0;
      tx_valid_q  <= 1'b0;
      wb_addr_q   <= '0;
      wb_wdata_q  <= '0;
      wb_wmsk_q   <= '0;
      wb_we_q     <= 1'b0;
      wb_cyc_q    <= 1'b0;
      busy_q      <= 1'b0;
      addr_hi_q   <= '0;
      byte_cnt_q  <= '0;
      rdata_q     <= '0;
      resp_left_q <= '0;
      ack_seen_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rx_ready_q  <= rx_ready_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
      wb_addr_q   <= wb_addr_d;
      wb_wdata_q  <= wb_wdata_d;
      wb_wmsk_q   <= wb_wmsk_d;
      wb_we_q     <= wb_we_d;
      wb_cyc_q    <= wb_cyc_d;
      busy_q      <= busy_d;
      addr_hi_q   <= addr_hi_d;
      byte_cnt_q  <= byte_cnt_d;
      rdata_q     <= rdata_d;
      resp_left_q <= resp_left_d;
      ack_seen_q  <= ack_seen_d;
    end
  end

  assign rx_ready = rx_ready_q;
  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign wb_addr  = wb_addr_q;
  assign wb_wdata = wb_wdata_q;
  assign wb_wmsk  = wb_wmsk_q;
  assign wb_we    = wb_we_q;
  assign wb_cyc   = wb_cyc_q;
  assign busy     = busy_q;

endmodule
